// File: rtl/io_pkg.sv
// Shared types for the LED I/O block: low-power sequencer states and
// the pad policies applied while the CPU sits in WFI.
package io_pkg;

    typedef enum logic [1:0] {
        StRun,
        StSettle,
        StSleep,
        StWake
    } io_state_e;

    // Pad policy while in SLEEP
    localparam int unsigned WfiHiZ  = 0;  // release the pads (led_oe low)
    localparam int unsigned WfiHold = 1;  // drive a static level captured on entry
    localparam int unsigned WfiLow  = 2;  // drive all pads low

endpackage

// File: rtl/io_led_pwm_timebase.sv
// PWM timebase: prescaler producing a tick every PRESCALE cycles and a
// PWM_BITS-wide period counter advanced on each tick.
module io_led_pwm_timebase
    import io_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    output logic                tick,
    output logic                wrap,
    output logic [PWM_BITS-1:0] cnt
);

    localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PresW-1:0]    PresLast = PresW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CntMax   = '1;

    logic [PresW-1:0]    presc_q;
    logic [PWM_BITS-1:0] cnt_q;

    assign tick = en & (presc_q == PresLast);
    assign wrap = tick & (cnt_q == CntMax);
    assign cnt  = cnt_q;

    // Prescaler and period counter; clr wins over en, en low freezes both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_led_pwm.sv
// Multi-channel LED controller: per-channel PWM with shadowed duty
// registers and a WFI sequence that finishes the PWM period, freezes the
// timebase and applies a pad policy while asleep.
module io_led_pwm
    import io_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned WFI_MODE = 0,
    parameter logic [PWM_BITS-1:0] DUTY_RST = '1,
    localparam int unsigned IDX_BITS = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] led_bus,
    input  logic                duty_we,
    input  logic [IDX_BITS-1:0] duty_idx,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic                wfi,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [NUM_LEDS-1:0] led_oe,
    output logic                wfi_ack
);

    localparam logic [PWM_BITS-1:0] DutyMax = '1;

    io_state_e           state_q;
    logic [PWM_BITS-1:0] shadow_q [NUM_LEDS];
    logic [PWM_BITS-1:0] active_q [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_out_q;
    logic [NUM_LEDS-1:0] led_oe_q;
    logic [NUM_LEDS-1:0] sleep_lvl_q;
    logic                wfi_ack_q;

    logic [NUM_LEDS-1:0] pwm_on;
    logic [NUM_LEDS-1:0] shadow_nz;
    logic                tick;
    logic                wrap;
    logic                period_end;
    logic [PWM_BITS-1:0] pwm_cnt;

    io_led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != StSleep),
        .clr   (state_q == StWake),
        .tick  (tick),
        .wrap  (wrap),
        .cnt   (pwm_cnt)
    );

    // Last tick of the PWM period: the point where SETTLE may go to sleep
    assign period_end = tick & (pwm_cnt == DutyMax);

    // Per-channel PWM compare; full-scale duty is solid on, zero duty is off
    always_comb begin
        pwm_on    = '0;
        shadow_nz = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            pwm_on[i]    = led_bus[i] & ((active_q[i] == DutyMax) | (pwm_cnt < active_q[i]));
            shadow_nz[i] = (shadow_q[i] != '0);
        end
    end

    // Duty registers: CPU writes the shadow, active copies it only at period
    // boundaries (and on wake) so a running period never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                shadow_q[i] <= DUTY_RST;
                active_q[i] <= DUTY_RST;
            end
        end else begin
            if (duty_we && (32'(duty_idx) < NUM_LEDS)) begin
                shadow_q[duty_idx] <= duty_wdata;
            end
            // Non-blocking read of shadow_q: a write on the wrap cycle lands next period
            if (wrap || (state_q == StWake)) begin
                for (int i = 0; i < int'(NUM_LEDS); i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // WFI sequencer with registered pad outputs and acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            led_out_q   <= '0;
            led_oe_q    <= '1;
            sleep_lvl_q <= '0;
            wfi_ack_q   <= 1'b0;
        end else begin
            // Pad policy follows the current state, so it lags state entry by one cycle
            if (state_q == StSleep) begin
                if (WFI_MODE == WfiHold) begin
                    led_out_q <= sleep_lvl_q;
                    led_oe_q  <= '1;
                end else if (WFI_MODE == WfiLow) begin
                    led_out_q <= '0;
                    led_oe_q  <= '1;
                end else begin
                    led_oe_q  <= '0;
                end
            end else begin
                led_out_q <= pwm_on;
                led_oe_q  <= '1;
            end

            unique case (state_q)
                StRun: begin
                    if (wfi) begin
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (!wfi) begin
                        state_q <= StRun;
                    end else if (period_end) begin
                        state_q     <= StSleep;
                        wfi_ack_q   <= 1'b1;
                        // Level reflects the duties that the final wrap loads into active
                        sleep_lvl_q <= led_bus & shadow_nz;
                    end
                end
                StSleep: begin
                    if (!wfi) begin
                        state_q   <= StWake;
                        wfi_ack_q <= 1'b0;
                    end
                end
                StWake: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign led_out = led_out_q;
    assign led_oe  = led_oe_q;
    assign wfi_ack = wfi_ack_q;

endmodule
